// File: rtl/register_file_2p.sv
// Two-port general-purpose register file: one write port (load/copy/inc/dec) and one
// registered read port sharing src_reg, with optional hardwired-zero register 0.
module register_file_2p #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 3,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_enable,
  input  logic [1:0]        wr_mode,
  input  logic [ADDR_W-1:0] dst_reg,
  input  logic [ADDR_W-1:0] src_reg,
  input  logic [WIDTH-1:0]  input_bus,
  input  logic              read_enable,
  output logic [WIDTH-1:0]  output_bus,
  output logic              output_valid,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic [WIDTH-1:0]  r1,
  output logic [WIDTH-1:0]  r2
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_COPY = 2'b01,
    MODE_INC  = 2'b10,
    MODE_DEC  = 2'b11
  } wr_mode_t;

  logic [WIDTH-1:0] regs [DEPTH];

  logic [WIDTH-1:0] src_val;
  logic [WIDTH-1:0] dst_val;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             commit;
  logic [WIDTH-1:0] rd_val;

  // Register 0 is masked on both read paths so copies and inc/dec see 0.
  always_comb begin
    src_val = regs[src_reg];
    dst_val = regs[dst_reg];
    if (ZERO_REG && (src_reg == '0)) src_val = '0;
    if (ZERO_REG && (dst_reg == '0)) dst_val = '0;
  end

  always_comb begin
    result = input_bus;
    carry  = 1'b0;
    case (wr_mode_t'(wr_mode))
      MODE_LOAD: result = input_bus;
      MODE_COPY: result = src_val;
      MODE_INC: begin
        result = dst_val + WIDTH'(1);
        carry  = (dst_val == '1);
      end
      MODE_DEC: begin
        result = dst_val - WIDTH'(1);
        carry  = (dst_val == '0);
      end
      default: result = input_bus;
    endcase
  end

  always_comb begin
    commit = write_enable && !(ZERO_REG && (dst_reg == '0));
    rd_val = src_val;
    if (BYPASS && commit && (dst_reg == src_reg)) rd_val = result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
    end else if (commit) begin
      regs[dst_reg] <= result;
      flag_zero     <= (result == '0);
      flag_carry    <= carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output_bus   <= '0;
      output_valid <= 1'b0;
    end else begin
      output_valid <= read_enable;
      if (read_enable) output_bus <= rd_val;
    end
  end

  assign r1 = regs[1];
  assign r2 = regs[2];

endmodule

// File: tb/tb_register_file_2p.sv
// Directed bench for register_file_2p: a vector table on the default build plus short
// sequences on BYPASS=0/ZERO_REG=0 and WIDTH=16/ADDR_W=4 builds.
module tb_register_file_2p;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Default build: WIDTH=8, ADDR_W=3, ZERO_REG=1, BYPASS=1
  logic       a_we = 1'b0, a_re = 1'b0;
  logic [1:0] a_mode = 2'd0;
  logic [2:0] a_dst = 3'd0, a_src = 3'd0;
  logic [7:0] a_din = 8'd0;
  logic [7:0] a_out, a_r1, a_r2;
  logic       a_valid, a_fz, a_fc;

  register_file_2p #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .write_enable(a_we), .wr_mode(a_mode), .dst_reg(a_dst),
    .src_reg(a_src), .input_bus(a_din), .read_enable(a_re), .output_bus(a_out),
    .output_valid(a_valid), .flag_zero(a_fz), .flag_carry(a_fc), .r1(a_r1), .r2(a_r2));

  // No bypass, ordinary register 0
  logic       b_we = 1'b0, b_re = 1'b0;
  logic [1:0] b_mode = 2'd0;
  logic [2:0] b_dst = 3'd0, b_src = 3'd0;
  logic [7:0] b_din = 8'd0;
  logic [7:0] b_out, b_r1, b_r2;
  logic       b_valid, b_fz, b_fc;

  register_file_2p #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .write_enable(b_we), .wr_mode(b_mode), .dst_reg(b_dst),
    .src_reg(b_src), .input_bus(b_din), .read_enable(b_re), .output_bus(b_out),
    .output_valid(b_valid), .flag_zero(b_fz), .flag_carry(b_fc), .r1(b_r1), .r2(b_r2));

  // Wide build
  logic        c_we = 1'b0, c_re = 1'b0;
  logic [1:0]  c_mode = 2'd0;
  logic [3:0]  c_dst = 4'd0, c_src = 4'd0;
  logic [15:0] c_din = 16'd0;
  logic [15:0] c_out, c_r1, c_r2;
  logic        c_valid, c_fz, c_fc;

  register_file_2p #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .write_enable(c_we), .wr_mode(c_mode), .dst_reg(c_dst),
    .src_reg(c_src), .input_bus(c_din), .read_enable(c_re), .output_bus(c_out),
    .output_valid(c_valid), .flag_zero(c_fz), .flag_carry(c_fc), .r1(c_r1), .r2(c_r2));

  typedef struct {
    logic       we;
    logic [1:0] mode;
    logic [2:0] dst;
    logic [2:0] src;
    logic [7:0] din;
    logic       re;
    logic [7:0] e_out;
    logic       e_valid;
    logic       e_fz;
    logic       e_fc;
    logic [7:0] e_r1;
    logic [7:0] e_r2;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, input logic [1:0] mode, input logic [2:0] dst,
                     input logic [2:0] src, input logic [7:0] din, input logic re,
                     input logic [7:0] e_out, input logic e_valid, input logic e_fz,
                     input logic e_fc, input logic [7:0] e_r1, input logic [7:0] e_r2);
    vec_t v;
    v.we = we; v.mode = mode; v.dst = dst; v.src = src; v.din = din; v.re = re;
    v.e_out = e_out; v.e_valid = e_valid; v.e_fz = e_fz; v.e_fc = e_fc;
    v.e_r1 = e_r1; v.e_r2 = e_r2;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic we, input logic [1:0] mode, input logic [2:0] dst,
                         input logic [2:0] src, input logic [7:0] din, input logic re);
    b_we = we; b_mode = mode; b_dst = dst; b_src = src; b_din = din; b_re = re;
    tick();
    b_we = 1'b0; b_re = 1'b0;
  endtask

  task automatic drive_c(input logic we, input logic [1:0] mode, input logic [3:0] dst,
                         input logic [3:0] src, input logic [15:0] din, input logic re);
    c_we = we; c_mode = mode; c_dst = dst; c_src = src; c_din = din; c_re = re;
    tick();
    c_we = 1'b0; c_re = 1'b0;
  endtask

  initial begin
    //   we    mode   dst   src   din    re    out    v     fz    fc    r1     r2
    add(1'b1, 2'd0, 3'd1, 3'd0, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h55, 8'h00);
    add(1'b1, 2'd0, 3'd2, 3'd0, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h55, 8'hAA);
    add(1'b1, 2'd1, 3'd5, 3'd1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h55, 8'hAA);
    add(1'b0, 2'd0, 3'd0, 3'd5, 8'h00, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h55, 8'hAA);
    add(1'b0, 2'd0, 3'd0, 3'd0, 8'h00, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 8'hAA);
    add(1'b1, 2'd0, 3'd3, 3'd0, 8'hFF, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 8'hAA);
    add(1'b1, 2'd2, 3'd3, 3'd0, 8'h00, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 8'hAA);
    add(1'b1, 2'd3, 3'd3, 3'd0, 8'h00, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 8'hAA);
    add(1'b0, 2'd0, 3'd0, 3'd3, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h55, 8'hAA);
    add(1'b1, 2'd0, 3'd4, 3'd4, 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h55, 8'hAA);
    add(1'b1, 2'd0, 3'd7, 3'd0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h55, 8'hAA);
    add(1'b1, 2'd0, 3'd0, 3'd0, 8'h99, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h55, 8'hAA);
    add(1'b1, 2'd2, 3'd0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h55, 8'hAA);
    add(1'b1, 2'd0, 3'd6, 3'd0, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h55, 8'hAA);
    add(1'b1, 2'd1, 3'd6, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h55, 8'hAA);
    add(1'b0, 2'd0, 3'd0, 3'd6, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h55, 8'hAA);
    add(1'b1, 2'd1, 3'd1, 3'd1, 8'h00, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h55, 8'hAA);
    add(1'b1, 2'd2, 3'd2, 3'd2, 8'h00, 1'b1, 8'hAB, 1'b1, 1'b0, 1'b0, 8'h55, 8'hAB);
    add(1'b1, 2'd3, 3'd4, 3'd4, 8'h00, 1'b1, 8'h3B, 1'b1, 1'b0, 1'b0, 8'h55, 8'hAB);
    add(1'b1, 2'd3, 3'd7, 3'd0, 8'h00, 1'b0, 8'h3B, 1'b0, 1'b0, 1'b1, 8'h55, 8'hAB);
    add(1'b0, 2'd0, 3'd0, 3'd7, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h55, 8'hAB);

    // Reset state, still held in reset
    #12;
    check("reset out", {8'h00, a_out}, 16'h0000);
    check("reset valid", {15'd0, a_valid}, 16'h0000);
    check("reset flags", {14'd0, a_fz, a_fc}, 16'h0000);
    check("reset r1r2", {a_r1, a_r2}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      a_we = vecs[i].we; a_mode = vecs[i].mode; a_dst = vecs[i].dst;
      a_src = vecs[i].src; a_din = vecs[i].din; a_re = vecs[i].re;
      tick();
      check($sformatf("vec%0d out", i), {8'h00, a_out}, {8'h00, vecs[i].e_out});
      check($sformatf("vec%0d valid", i), {15'd0, a_valid}, {15'd0, vecs[i].e_valid});
      check($sformatf("vec%0d flags", i), {14'd0, a_fz, a_fc},
            {14'd0, vecs[i].e_fz, vecs[i].e_fc});
      check($sformatf("vec%0d r1r2", i), {a_r1, a_r2}, {vecs[i].e_r1, vecs[i].e_r2});
    end
    a_we = 1'b0; a_re = 1'b1; a_src = 3'd1;

    // Asynchronous reset mid-cycle while a read is pending and state is non-zero
    #3;
    rst_n = 1'b0;
    #1;
    check("async out", {8'h00, a_out}, 16'h0000);
    check("async valid", {15'd0, a_valid}, 16'h0000);
    check("async flags", {14'd0, a_fz, a_fc}, 16'h0000);
    check("async r1r2", {a_r1, a_r2}, 16'h0000);
    check("async wide r", c_r1, 16'h0000);
    a_re = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post reset valid", {15'd0, a_valid}, 16'h0000);

    // BYPASS=0, ZERO_REG=0
    drive_b(1'b1, 2'd0, 3'd4, 3'd4, 8'h3C, 1'b1);
    check("b nobypass out", {8'h00, b_out}, 16'h0000);
    check("b nobypass valid", {15'd0, b_valid}, 16'h0001);
    drive_b(1'b0, 2'd0, 3'd0, 3'd4, 8'h00, 1'b1);
    check("b read4", {8'h00, b_out}, 16'h003C);
    drive_b(1'b1, 2'd0, 3'd0, 3'd0, 8'h99, 1'b1);
    check("b reg0 pre", {8'h00, b_out}, 16'h0000);
    drive_b(1'b0, 2'd0, 3'd0, 3'd0, 8'h00, 1'b1);
    check("b reg0 read", {8'h00, b_out}, 16'h0099);
    check("b flags", {14'd0, b_fz, b_fc}, 16'h0000);
    drive_b(1'b1, 2'd0, 3'd0, 3'd0, 8'h00, 1'b0);
    check("b reg0 zero flag", {14'd0, b_fz, b_fc}, 16'h0002);
    check("b hold valid", {15'd0, b_valid}, 16'h0000);
    drive_b(1'b1, 2'd2, 3'd1, 3'd1, 8'h00, 1'b1);
    check("b inc pre", {8'h00, b_out}, 16'h0000);
    check("b r1", {8'h00, b_r1}, 16'h0001);

    // WIDTH=16, ADDR_W=4
    drive_c(1'b1, 2'd0, 4'd15, 4'd0, 16'hFFFF, 1'b0);
    check("c load flags", {14'd0, c_fz, c_fc}, 16'h0000);
    drive_c(1'b1, 2'd2, 4'd15, 4'd0, 16'h0000, 1'b0);
    check("c inc flags", {14'd0, c_fz, c_fc}, 16'h0003);
    drive_c(1'b0, 2'd0, 4'd0, 4'd15, 16'h0000, 1'b1);
    check("c read15", c_out, 16'h0000);
    check("c read valid", {15'd0, c_valid}, 16'h0001);
    drive_c(1'b1, 2'd3, 4'd15, 4'd15, 16'h0000, 1'b1);
    check("c dec bypass", c_out, 16'hFFFF);
    check("c dec flags", {14'd0, c_fz, c_fc}, 16'h0001);
    tick();
    check("c valid drop", {15'd0, c_valid}, 16'h0000);
    check("c out hold", c_out, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
